// File: rtl/dmio_pkg.sv
// dmio_pkg: shared LSU state, size encodings and DMIO constants
package dmio_pkg;
  typedef enum logic [2:0] {IDLE, RD, WR, ERR, RESP} lsu_state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [63:0] IO_BASE = 64'h1000;
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    return size == SZ_H ? off[0] : size == SZ_W ? |off[1:0] : size == SZ_D ? |off : 1'b0;
  endfunction
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    return size == SZ_B ? 64'hFF : size == SZ_H ? 64'hFFFF : size == SZ_W ? 64'hFFFF_FFFF : '1;
  endfunction
endpackage

// File: rtl/dmio_lane_align.sv
// dmio_lane_align: byte-lane extract/extend for loads and merge for sub-double stores
module dmio_lane_align
  import dmio_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] ext,
  output logic [63:0] merged
);
  logic [5:0]  lane;
  logic [63:0] sh;
  logic [63:0] m;
  logic        sb;
  always_comb begin
    lane   = {off, 3'b000};
    sh     = rdata >> lane;
    m      = size_mask(size);
    sb     = sgn & (size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : sh[31]);
    ext    = size == SZ_D ? sh : (sh & m) | ({64{sb}} & ~m);
    merged = (rdata & ~(m << lane)) | ((wdata & m) << lane);
  end
endmodule

// File: rtl/dmio_lsu.sv
// dmio_lsu: load/store initiator for DMIO; sub-double stores are read-modify-write
module dmio_lsu
  import dmio_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_write,
  output logic              enable_write,
  input  logic [DATA_W-1:0] data_read
);
  lsu_state_t        state, state_n, route;
  logic              accept;
  logic [1:0]        cnt;
  logic              wr_q;
  logic [1:0]        sz_q;
  logic              sgn_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] merged;

  dmio_lane_align u_align (
    .off    (off_q),
    .size   (sz_q),
    .sgn    (sgn_q),
    .rdata  (data_read),
    .wdata  (wdata_q),
    .ext    (ext),
    .merged (merged)
  );

  assign req_ready    = state == IDLE;
  assign resp_valid   = state == RESP;
  assign enable_write = state == WR;
  assign accept       = req_valid && req_ready;

  // An error needs no DMIO cycle, so ERR folds straight into RESP on acceptance
  always_comb begin
    route   = misaligned(req_size, req_addr[2:0]) ? ERR : (req_write && req_size == SZ_D) ? WR : RD;
    state_n = state == IDLE ? (accept ? (route == ERR ? RESP : route) : IDLE) :
              state == RD   ? (cnt == 2'd0 ? (wr_q ? WR : RESP) : RD) :
              state == RESP ? (resp_ready ? IDLE : RESP) :
              state == WR || state == ERR ? RESP : IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      wr_q       <= 1'b0;
      sz_q       <= SZ_B;
      sgn_q      <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      address    <= '0;
      data_write <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt        <= 2'(RD_LAT);
        wr_q       <= req_write;
        sz_q       <= req_size;
        sgn_q      <= req_signed;
        off_q      <= req_addr[2:0];
        wdata_q    <= req_wdata;
        resp_err   <= route == ERR;
        resp_rdata <= '0;
        if (route != ERR) address <= {req_addr[ADDR_W-1:3], 3'b000};
        if (route == WR) data_write <= req_wdata;
      end
      if (state == RD) begin
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
        else if (wr_q) data_write <= merged;
        else resp_rdata <= ext;
      end
    end
  end
endmodule

// File: tb/tb_dmio_lsu.sv
// tb_dmio_lsu: directed checks of dmio_lsu against a 1-cycle registered DMIO model
module tb_dmio_lsu;
  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0, req_ready, req_write = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_ready = 0, resp_err, enable_write;
  logic [63:0] resp_rdata, address, data_write, data_read;
  logic [63:0] mem [0:127];
  logic [63:0] last_wa, last_wd;
  int          wr_cnt = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmio_lsu #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .data_write(data_write), .enable_write(enable_write),
    .data_read(data_read)
  );

  always @(posedge clk) begin
    data_read <= mem[address[9:3]];
    if (enable_write) begin
      mem[address[9:3]] <= data_write;
      last_wa = address;
      last_wd = data_write;
      wr_cnt++;
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [63:0] a, input logic [63:0] wd, output int lat);
    @(negedge clk);
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
  endtask

  task automatic consume;
    @(negedge clk);
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", resp_valid); end
    checks++; if (enable_write !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", enable_write); end
    checks++; if (address !== 64'h0 || data_write !== 64'h0) begin errors++; $display("FAIL rst_bus got %h/%h want 0/0", address, data_write); end
    checks++; if (resp_rdata !== 64'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got %h/%b want 0/0", resp_rdata, resp_err); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_double_store;
    int lat, w0;
    w0 = wr_cnt;
    issue(1, 2'd3, 0, 64'h1000, 64'd7, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dst_lat got %0d want 2", lat); end
    checks++; if (wr_cnt - w0 !== 1 || last_wa !== 64'h1000 || last_wd !== 64'd7) begin errors++; $display("FAIL dst_write got n=%0d a=%h d=%h want 1/1000/7", wr_cnt - w0, last_wa, last_wd); end
    checks++; if (resp_err !== 1'b0 || resp_rdata !== 64'h0) begin errors++; $display("FAIL dst_resp got %b/%h want 0/0", resp_err, resp_rdata); end
    consume();
    issue(1, 2'd3, 0, 64'h1000, 64'h8877665544332211, lat);
    checks++; if (lat !== 2 || last_wd !== 64'h8877665544332211) begin errors++; $display("FAIL preload got lat=%0d d=%h want 2/8877665544332211", lat, last_wd); end
    consume();
  endtask

  task automatic test_loads;
    int lat, w0;
    logic [1:0]  sz [0:4] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    logic        sg [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] ad [0:4] = '{64'h1007, 64'h1007, 64'h1004, 64'h1004, 64'h1004};
    logic [63:0] ex [0:4] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h6655, 64'h88776655, 64'hFFFFFFFF88776655};
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      issue(0, sz[i], sg[i], ad[i], 64'h0, lat);
      checks++; if (lat !== 3 || resp_err !== 1'b0) begin errors++; $display("FAIL ld%0d_lat got %0d/%b want 3/0", i, lat, resp_err); end
      checks++; if (resp_rdata !== ex[i]) begin errors++; $display("FAIL ld%0d_data got %h want %h", i, resp_rdata, ex[i]); end
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL ld%0d_nowrite got %0d writes want 0", i, wr_cnt - w0); end
      consume();
    end
  endtask

  task automatic test_sub_store;
    int lat, w0;
    w0 = wr_cnt;
    issue(1, 2'd1, 0, 64'h1002, 64'h1234BEEF, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL hst_lat got %0d want 4", lat); end
    checks++; if (wr_cnt - w0 !== 1 || last_wa !== 64'h1000 || last_wd !== 64'h88776655BEEF2211) begin errors++; $display("FAIL hst_write got n=%0d a=%h d=%h want 1/1000/88776655beef2211", wr_cnt - w0, last_wa, last_wd); end
    consume();
    issue(1, 2'd0, 0, 64'h1007, 64'hFFAB, lat);
    checks++; if (lat !== 4 || last_wd !== 64'hAB776655BEEF2211) begin errors++; $display("FAIL bst_write got lat=%0d d=%h want 4/ab776655beef2211", lat, last_wd); end
    consume();
    issue(0, 2'd3, 0, 64'h1000, 64'h0, lat);
    checks++; if (resp_rdata !== 64'hAB776655BEEF2211) begin errors++; $display("FAIL dld_data got %h want ab776655beef2211", resp_rdata); end
    consume();
  endtask

  task automatic test_misaligned;
    int lat, w0;
    logic        wr [0:2] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [0:2] = '{2'd2, 2'd1, 2'd3};
    logic [63:0] ad [0:2] = '{64'h0003, 64'h1001, 64'h1004};
    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt;
      issue(wr[i], sz[i], 1'b1, ad[i], 64'hDEAD, lat);
      checks++; if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 64'h0) begin errors++; $display("FAIL mis%0d got lat=%0d err=%b d=%h want 1/1/0", i, lat, resp_err, resp_rdata); end
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL mis%0d_nowrite got %0d writes want 0", i, wr_cnt - w0); end
      consume();
    end
  endtask

  task automatic test_back_to_back;
    int lat, w0, n;
    w0 = wr_cnt;
    issue(0, 2'd1, 0, 64'h1002, 64'h0, lat);
    req_valid = 1; req_write = 1; req_size = 2'd3; req_addr = 64'h1008; req_wdata = 64'h55;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 64'hBEEF || req_ready !== 1'b0) begin errors++; $display("FAIL hold%0d got v=%b d=%h rdy=%b want 1/beef/0", i, resp_valid, resp_rdata, req_ready); end
      @(negedge clk);
    end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL hold_nowrite got %0d writes want 0", wr_cnt - w0); end
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL release got rdy=%b v=%b want 1/0", req_ready, resp_valid); end
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (wr_cnt - w0 !== 1 || last_wa !== 64'h1008 || last_wd !== 64'h55) begin errors++; $display("FAIL second_req got n=%0d a=%h d=%h want 1/1008/55", wr_cnt - w0, last_wa, last_wd); end
    consume();
  endtask

  task automatic test_reset_mid;
    int lat, w0;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_size = 2'd3; req_addr = 64'h1000;
    @(posedge clk);
    #1 req_valid = 0;
    reset = 1;
    #1;
    checks++; if (req_ready !== 1'b1 || enable_write !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rd got rdy=%b we=%b v=%b want 1/0/0", req_ready, enable_write, resp_valid); end
    @(negedge clk);
    reset = 0;
    req_valid = 1; req_write = 1; req_size = 2'd0; req_addr = 64'h1000; req_wdata = 64'h99;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (enable_write !== 1'b1) begin errors++; $display("FAIL pre_rst_wr got we=%b want 1", enable_write); end
    reset = 1;
    #1;
    checks++; if (enable_write !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_wr got we=%b rdy=%b want 0/1", enable_write, req_ready); end
    @(negedge clk);
    reset = 0;
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL rst_nowrite got %0d writes want 0", wr_cnt - w0); end
    issue(0, 2'd3, 0, 64'h1000, 64'h0, lat);
    checks++; if (resp_rdata !== 64'hAB776655BEEF2211) begin errors++; $display("FAIL rst_mem got %h want ab776655beef2211", resp_rdata); end
    consume();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 64'h0;
    test_reset();
    test_double_store();
    test_loads();
    test_sub_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
